// File: rtl/wbm_arb_pkg.sv
// Shared definitions for the Wishbone burst arbiter.
// - state_t   : burst sequencer states
// - num_req_c : number of requesters sharing the master port
package wbm_arb_pkg;

    localparam int num_req_c = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter.
// Ports:
//   clock, rst : clock and synchronous active-high reset
//   en_i       : arbitration allowed this cycle (grants only while enabled)
//   req_i      : request per requester
//   gnt_o      : one-hot grant, combinational from req_i
// The last-grant pointer moves on every issued grant. On a tie the
// requester that was not granted last wins; reset favours requester 0.
module rr_arbiter2 (
    input  logic       clock,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        if (en_i) begin
            if (req_i == 2'b11) begin
                gnt_o = last_q ? 2'b01 : 2'b10;
            end else begin
                gnt_o = req_i;
            end
            if (req_i != 2'b00) begin
                last_d = gnt_o[1];
            end
        end
    end

    // Pointer resets to "requester 1 granted last" so requester 0 wins first.
    always_ff @(posedge clock) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/wbm_burst_arbiter.sv
// Shares one pipelined Wishbone master port between two requesters.
// Arbitrates round-robin, latches the winner's command and runs one burst,
// finishing on the last acknowledge, on bus error or on watchdog expiry.
// Ports:
//   clock, rst          : clock, synchronous active-high reset
//   req_*_i / gnt_o     : per-requester command and one-cycle grant
//   wr_dat_i / wr_ack_o : write data per requester and its consume pulse
//   rd_dat_o / rd_val_o : shared read data and per-requester valid pulse
//   done_o / err_o      : per-requester completion and failure pulses
//   wbm_*               : Wishbone master port
//   dbg_state_o         : current sequencer state
//
// Handshakes: a requester holds req_i and its command fields until it sees
// gnt_o; the fields are sampled in the gnt_o cycle. On the bus a strobe is
// transferred in a cycle with stb=1 and stall=0 (wr_ack_o pulses in that same
// cycle, and the requester moves to its next word on the following cycle);
// each ack retires one strobe, and err ends the burst immediately.
module wbm_burst_arbiter
    import wbm_arb_pkg::*;
#(
    parameter int data_width_g = 8,
    parameter int blen_width_g = 9,
    parameter int addr_width_g = 10,
    parameter int timeout_g    = 255
) (
    input  logic                                     clock,
    input  logic                                     rst,
    input  logic [num_req_c-1:0]                     req_i,
    output logic [num_req_c-1:0]                     gnt_o,
    input  logic [num_req_c-1:0]                     req_we_i,
    input  logic [num_req_c-1:0][addr_width_g-1:0]   req_adr_i,
    input  logic [num_req_c-1:0][blen_width_g-1:0]   req_len_i,
    input  logic [num_req_c-1:0]                     req_tgc_i,
    input  logic [num_req_c-1:0]                     req_tgd_i,
    input  logic [num_req_c-1:0][data_width_g-1:0]   wr_dat_i,
    output logic [num_req_c-1:0]                     wr_ack_o,
    output logic [data_width_g-1:0]                  rd_dat_o,
    output logic [num_req_c-1:0]                     rd_val_o,
    output logic [num_req_c-1:0]                     done_o,
    output logic [num_req_c-1:0]                     err_o,
    output logic                                     wbm_cyc_o,
    output logic                                     wbm_stb_o,
    output logic                                     wbm_we_o,
    output logic [addr_width_g-1:0]                  wbm_adr_o,
    output logic [blen_width_g-1:0]                  wbm_tga_o,
    output logic [data_width_g-1:0]                  wbm_dat_o,
    output logic                                     wbm_tgc_o,
    output logic                                     wbm_tgd_o,
    input  logic [data_width_g-1:0]                  wbm_dat_i,
    input  logic                                     wbm_stall_i,
    input  logic                                     wbm_ack_i,
    input  logic                                     wbm_err_i,
    output logic [1:0]                               dbg_state_o
);

    // One extra bit so len+1 never overflows the burst counters.
    localparam int cnt_w_c  = blen_width_g + 1;
    localparam int wdog_w_c = $clog2(timeout_g + 1);

    state_t                    state_q, state_d;
    logic                      owner_q, owner_d;
    logic                      we_q, we_d;
    logic [addr_width_g-1:0]   adr_q, adr_d;
    logic [blen_width_g-1:0]   tga_q, tga_d;
    logic                      tgc_q, tgc_d;
    logic                      tgd_q, tgd_d;
    logic [cnt_w_c-1:0]        stb_cnt_q, stb_cnt_d;
    logic [cnt_w_c-1:0]        ack_cnt_q, ack_cnt_d;
    logic [wdog_w_c-1:0]       wdog_q, wdog_d;
    logic                      abort_q, abort_d;
    logic [data_width_g-1:0]   rd_dat_q, rd_dat_d;
    logic [num_req_c-1:0]      rd_val_q, rd_val_d;

    logic [num_req_c-1:0]      gnt;
    logic                      gnt_idx;
    logic [num_req_c-1:0]      owner_oh;
    logic                      in_burst;
    logic                      stb;
    logic                      accept;
    logic                      ack_ok;
    logic                      err_hit;
    logic                      wd_expire;

    rr_arbiter2 u_arb (
        .clock (clock),
        .rst   (rst),
        .en_i  ((state_q == IDLE) && !rst),
        .req_i (req_i),
        .gnt_o (gnt)
    );

    assign gnt_idx   = gnt[1];
    assign owner_oh  = owner_q ? 2'b10 : 2'b01;
    assign in_burst  = (state_q == ISSUE) || (state_q == DRAIN);
    assign stb       = (state_q == ISSUE);
    assign accept    = stb && !wbm_stall_i;
    // An ack coincident with err is dropped; acks beyond the burst are ignored.
    assign ack_ok    = in_burst && wbm_ack_i && !wbm_err_i && (ack_cnt_q != '0);
    assign err_hit   = in_burst && wbm_err_i;
    assign wd_expire = in_burst && !wbm_ack_i && (wdog_q == wdog_w_c'(1));

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        adr_d     = adr_q;
        tga_d     = tga_q;
        tgc_d     = tgc_q;
        tgd_d     = tgd_q;
        stb_cnt_d = stb_cnt_q;
        ack_cnt_d = ack_cnt_q;
        wdog_d    = wdog_q;
        abort_d   = abort_q;
        rd_dat_d  = rd_dat_q;
        rd_val_d  = '0;

        if (ack_ok && !we_q) begin
            rd_dat_d = wbm_dat_i;
            rd_val_d = owner_oh;
        end

        case (state_q)
            IDLE: begin
                if (gnt != '0) begin
                    owner_d   = gnt_idx;
                    we_d      = req_we_i[gnt_idx];
                    adr_d     = req_adr_i[gnt_idx];
                    tga_d     = req_len_i[gnt_idx] + blen_width_g'(1);
                    tgc_d     = req_tgc_i[gnt_idx];
                    tgd_d     = req_tgd_i[gnt_idx];
                    stb_cnt_d = {1'b0, req_len_i[gnt_idx]} + cnt_w_c'(1);
                    ack_cnt_d = {1'b0, req_len_i[gnt_idx]} + cnt_w_c'(1);
                    wdog_d    = wdog_w_c'(timeout_g);
                    abort_d   = 1'b0;
                    state_d   = ISSUE;
                end
            end
            ISSUE, DRAIN: begin
                if (accept) begin
                    stb_cnt_d = stb_cnt_q - cnt_w_c'(1);
                    adr_d     = adr_q + addr_width_g'(1);
                end
                if (ack_ok) begin
                    ack_cnt_d = ack_cnt_q - cnt_w_c'(1);
                end
                wdog_d = wbm_ack_i ? wdog_w_c'(timeout_g) : wdog_q - wdog_w_c'(1);

                if (err_hit || wd_expire) begin
                    abort_d = 1'b1;
                    state_d = FINISH;
                end else if (ack_ok && (ack_cnt_q == cnt_w_c'(1))) begin
                    state_d = FINISH;
                end else if (accept && (stb_cnt_q == cnt_w_c'(1))) begin
                    state_d = DRAIN;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            tga_q     <= '0;
            tgc_q     <= 1'b0;
            tgd_q     <= 1'b0;
            stb_cnt_q <= '0;
            ack_cnt_q <= '0;
            wdog_q    <= '0;
            abort_q   <= 1'b0;
            rd_dat_q  <= '0;
            rd_val_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            tga_q     <= tga_d;
            tgc_q     <= tgc_d;
            tgd_q     <= tgd_d;
            stb_cnt_q <= stb_cnt_d;
            ack_cnt_q <= ack_cnt_d;
            wdog_q    <= wdog_d;
            abort_q   <= abort_d;
            rd_dat_q  <= rd_dat_d;
            rd_val_q  <= rd_val_d;
        end
    end

    assign gnt_o       = gnt;
    assign wr_ack_o    = (accept && we_q) ? owner_oh : '0;
    assign rd_dat_o    = rd_dat_q;
    assign rd_val_o    = rd_val_q;
    assign done_o      = (state_q == FINISH) ? owner_oh : '0;
    assign err_o       = ((state_q == FINISH) && abort_q) ? owner_oh : '0;
    assign wbm_cyc_o   = in_burst;
    assign wbm_stb_o   = stb;
    assign wbm_we_o    = we_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_tga_o   = tga_q;
    assign wbm_tgc_o   = tgc_q;
    assign wbm_tgd_o   = tgd_q;
    assign wbm_dat_o   = (stb && we_q) ? wr_dat_i[owner_q] : '0;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wbm_burst_arbiter.sv
// Bench for wbm_burst_arbiter: a transaction-level slave/requester model
// predicts grants, strobe addresses, write pacing, read returns and how each
// burst ends; every observation is checked with an immediate assertion.
module tb_wbm_burst_arbiter;

    localparam int DW  = 8;
    localparam int BW  = 9;
    localparam int AW  = 10;
    localparam int TMO = 8;

    logic                clock = 1'b0;
    logic                rst;
    logic [1:0]          req_i, gnt_o, req_we_i, req_tgc_i, req_tgd_i;
    logic [1:0][AW-1:0]  req_adr_i;
    logic [1:0][BW-1:0]  req_len_i;
    logic [1:0][DW-1:0]  wr_dat_i;
    logic [1:0]          wr_ack_o, rd_val_o, done_o, err_o, dbg_state_o;
    logic [DW-1:0]       rd_dat_o, wbm_dat_o, wbm_dat_i;
    logic                wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_tgc_o, wbm_tgd_o;
    logic [AW-1:0]       wbm_adr_o;
    logic [BW-1:0]       wbm_tga_o;
    logic                wbm_stall_i, wbm_ack_i, wbm_err_i;

    int                  n_pass  = 0;
    int                  n_total = 0;
    logic [DW-1:0]       words[0:63];
    logic [DW-1:0]       exp_q[$];
    int                  last_gnt = 1;
    int                  cyc_obs, done_obs, err_obs, wack_obs;

    wbm_burst_arbiter #(
        .data_width_g (DW),
        .blen_width_g (BW),
        .addr_width_g (AW),
        .timeout_g    (TMO)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .req_we_i    (req_we_i),
        .req_adr_i   (req_adr_i),
        .req_len_i   (req_len_i),
        .req_tgc_i   (req_tgc_i),
        .req_tgd_i   (req_tgd_i),
        .wr_dat_i    (wr_dat_i),
        .wr_ack_o    (wr_ack_o),
        .rd_dat_o    (rd_dat_o),
        .rd_val_o    (rd_val_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_tga_o   (wbm_tga_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_tgc_o   (wbm_tgc_o),
        .wbm_tgd_o   (wbm_tgd_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_stall_i (wbm_stall_i),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_err_i   (wbm_err_i),
        .dbg_state_o (dbg_state_o)
    );

    // Clock
    always #5 clock = ~clock;

    // Safety net in case the run stops making progress
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt"},    gnt_o,       0);
        chk({tag, "_wr_ack"}, wr_ack_o,    0);
        chk({tag, "_rd_dat"}, rd_dat_o,    0);
        chk({tag, "_rd_val"}, rd_val_o,    0);
        chk({tag, "_done"},   done_o,      0);
        chk({tag, "_err"},    err_o,       0);
        chk({tag, "_cyc"},    wbm_cyc_o,   0);
        chk({tag, "_stb"},    wbm_stb_o,   0);
        chk({tag, "_we"},     wbm_we_o,    0);
        chk({tag, "_adr"},    wbm_adr_o,   0);
        chk({tag, "_tga"},    wbm_tga_o,   0);
        chk({tag, "_dat"},    wbm_dat_o,   0);
        chk({tag, "_tgc"},    wbm_tgc_o,   0);
        chk({tag, "_tgd"},    wbm_tgd_o,   0);
        chk({tag, "_state"},  dbg_state_o, 0);
    endtask

    task automatic fill_words();
        for (int i = 0; i < 64; i++) words[i] = DW'($urandom);
    endtask

    // One request + burst. Slave acks each accepted strobe 'lat' cycles later
    // (unless no_ack), raises err together with ack number err_at, stalls the
    // first stall_first cycles then randomly with stall_pct percent.
    task automatic run_burst(input string name, input logic [1:0] mask, input bit hold,
                             input bit we, input logic [AW-1:0] adr, input int len,
                             input int lat, input int stall_pct, input int stall_first,
                             input int err_at, input bit no_ack, input int rst_at);
        int       win, k, acks, noack;
        logic [1:0] oh;
        bit       exp_done, exp_abort, rd_pend, fin, ack_now, err_now, acc, stall, tgc_w, tgd_w;
        int       ack_due[$];

        cyc_obs = 0; done_obs = 0; err_obs = 0; wack_obs = 0;
        if (mask == 2'b11) win = (last_gnt == 0) ? 1 : 0;
        else               win = mask[1] ? 1 : 0;
        oh = 2'b01 << win;

        for (int r = 0; r < 2; r++) begin
            req_we_i[r]  = 1'($urandom_range(0, 1));
            req_adr_i[r] = AW'($urandom);
            req_len_i[r] = BW'($urandom);
            req_tgc_i[r] = 1'($urandom_range(0, 1));
            req_tgd_i[r] = 1'($urandom_range(0, 1));
            wr_dat_i[r]  = DW'($urandom);
        end
        tgc_w = 1'($urandom_range(0, 1));
        tgd_w = 1'($urandom_range(0, 1));
        req_we_i[win]  = we;
        req_adr_i[win] = adr;
        req_len_i[win] = BW'(len);
        req_tgc_i[win] = tgc_w;
        req_tgd_i[win] = tgd_w;

        @(posedge clock); #1;
        req_i = mask;
        #1;
        chk({name, "_gnt"}, gnt_o, oh);
        if (gnt_o !== oh) begin
            req_i = 2'b00;
            return;
        end
        last_gnt = win;

        k = 0; acks = 0; noack = 0;
        exp_done = 0; exp_abort = 0; rd_pend = 0; fin = 0;
        for (int c = 1; c <= 300 && !fin; c++) begin
            @(posedge clock); #1;
            if (!hold) req_i[win] = 1'b0;
            if (rst_at > 0 && c == rst_at + 1) begin
                rst = 1'b0;
                wbm_stall_i = 0; wbm_ack_i = 0; wbm_err_i = 0;
                #1;
                check_zero({name, "_after_rst"});
                exp_q.delete();
                last_gnt = 1;
                fin = 1;
            end else begin
                wr_dat_i[win] = words[k];
                stall = (c <= stall_first) || ($urandom_range(1, 100) <= stall_pct);
                acc = !exp_done && (k <= len) && !stall;
                if (acc && !no_ack) ack_due.push_back(c + lat);
                ack_now = !exp_done && (ack_due.size() > 0) && (ack_due[0] == c);
                if (ack_now) void'(ack_due.pop_front());
                err_now = ack_now && (acks == err_at);
                wbm_stall_i = stall;
                wbm_ack_i   = ack_now;
                wbm_err_i   = err_now;
                wbm_dat_i   = (ack_now && !we) ? words[acks] : DW'($urandom);
                if (c == rst_at) rst = 1'b1;
                #1;

                if (wbm_cyc_o === 1'b1) cyc_obs++;
                if (done_o[win] === 1'b1) done_obs++;
                if (err_o[win] === 1'b1) err_obs++;
                if (wr_ack_o[win] === 1'b1) wack_obs++;

                chk({name, "_gnt_idle"}, gnt_o, 0);
                if (rd_pend) begin
                    chk({name, "_rd_val"}, rd_val_o, oh);
                    chk({name, "_rd_dat"}, rd_dat_o, exp_q.pop_front());
                end else begin
                    chk({name, "_rd_val_idle"}, rd_val_o, 0);
                end
                rd_pend = 0;

                if (exp_done) begin
                    chk({name, "_done"}, done_o, oh);
                    chk({name, "_err"},  err_o, exp_abort ? oh : 2'b00);
                    chk({name, "_cyc_end"}, wbm_cyc_o, 0);
                    chk({name, "_stb_end"}, wbm_stb_o, 0);
                    fin = 1;
                end else begin
                    chk({name, "_done_early"}, done_o, 0);
                    chk({name, "_cyc"}, wbm_cyc_o, 1);
                    chk({name, "_stb"}, wbm_stb_o, (k <= len));
                    chk({name, "_wr_ack"}, wr_ack_o, (acc && we) ? oh : 2'b00);
                    chk({name, "_wdat"}, wbm_dat_o, (k <= len && we) ? words[k] : 8'h00);
                    if (c == 1) begin
                        chk({name, "_we"},  wbm_we_o,  we);
                        chk({name, "_tga"}, wbm_tga_o, BW'(len + 1));
                        chk({name, "_tgc"}, wbm_tgc_o, tgc_w);
                        chk({name, "_tgd"}, wbm_tgd_o, tgd_w);
                    end
                    if (acc) begin
                        chk({name, "_adr"}, wbm_adr_o, AW'(adr + AW'(k)));
                        k++;
                    end
                    if (err_now) begin
                        exp_done = 1; exp_abort = 1;
                    end else if (ack_now) begin
                        noack = 0;
                        acks++;
                        if (!we) begin
                            exp_q.push_back(words[acks - 1]);
                            rd_pend = 1;
                        end
                        if (acks == len + 1) exp_done = 1;
                    end else begin
                        noack++;
                        if (noack == TMO) begin
                            exp_done = 1; exp_abort = 1;
                        end
                    end
                end
            end
        end
        chk({name, "_finished"}, fin, 1);
        chk({name, "_rd_left"}, exp_q.size(), 0);
        exp_q.delete();
        wbm_stall_i = 0; wbm_ack_i = 0; wbm_err_i = 0;
        rst = 1'b0;
    endtask

    initial begin
        // Reset and idle inputs
        rst = 1'b1;
        req_i = 0; req_we_i = 0; req_adr_i = '0; req_len_i = '0;
        req_tgc_i = 0; req_tgd_i = 0; wr_dat_i = '0;
        wbm_dat_i = 0; wbm_stall_i = 0; wbm_ack_i = 0; wbm_err_i = 0;
        repeat (3) @(posedge clock);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Single 4-word write, ack one cycle after each strobe
        fill_words();
        run_burst("wr1", 2'b01, 0, 1, 10'h010, 3, 1, 0, 0, -1, 0, -1);
        chk("wr1_cyc_cycles", cyc_obs, 5);
        chk("wr1_wr_acks", wack_obs, 4);
        chk("wr1_done_cnt", done_obs, 1);
        chk("wr1_err_cnt", err_obs, 0);

        // Two-word read, first strobe stalled two cycles
        fill_words();
        words[0] = 8'hA5;
        words[1] = 8'h5A;
        run_burst("rd_stall", 2'b10, 0, 0, AW'($urandom), 1, 0, 0, 2, -1, 0, -1);
        chk("rd_stall_cyc_cycles", cyc_obs, 4);
        chk("rd_stall_done_cnt", done_obs, 1);

        // Minimum burst: ack with the only strobe, done the cycle after
        fill_words();
        run_burst("min", 2'b10, 0, 1, AW'($urandom), 0, 0, 0, 0, -1, 0, -1);
        chk("min_cyc_cycles", cyc_obs, 1);

        // Contention with both requests held: grants alternate 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            fill_words();
            run_burst("contend", 2'b11, 1, 1'($urandom_range(0, 1)), AW'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 2), 20, 0, -1, 0, -1);
            chk("contend_owner", last_gnt, (i % 2));
        end
        req_i = 2'b00;

        // Error together with the second ack of a 4-word write
        fill_words();
        run_burst("err_wr", 2'b01, 0, 1, AW'($urandom), 3, 1, 0, 0, 1, 0, -1);
        chk("err_wr_cyc_cycles", cyc_obs, 3);
        chk("err_wr_err_cnt", err_obs, 1);

        // Error on the first ack of a read: no read data delivered
        fill_words();
        run_burst("err_rd", 2'b10, 0, 0, AW'($urandom), 2, 0, 0, 0, 0, 0, -1);
        chk("err_rd_err_cnt", err_obs, 1);

        // Watchdog: no acks at all
        fill_words();
        run_burst("tmo", 2'b01, 0, 1, AW'($urandom), 1, 0, 0, 0, -1, 1, -1);
        chk("tmo_cyc_cycles", cyc_obs, TMO);
        chk("tmo_err_cnt", err_obs, 1);

        // Reset while draining, then requester 1 served normally
        fill_words();
        run_burst("rst_mid", 2'b01, 0, 0, AW'($urandom), 1, 0, 0, 0, -1, 1, 3);
        chk("rst_mid_done_cnt", done_obs, 0);
        fill_words();
        run_burst("post_rst", 2'b10, 0, 1, AW'($urandom), 2, 1, 0, 0, -1, 0, -1);
        chk("post_rst_done_cnt", done_obs, 1);

        // Address wrap at the top of the address space
        fill_words();
        run_burst("wrap", 2'b01, 0, 1, 10'h3FE, 3, 2, 0, 0, -1, 0, -1);

        // Randomized bursts
        for (int i = 0; i < 16; i++) begin
            logic [1:0] m;
            int         l;
            m = 2'($urandom_range(1, 3));
            l = $urandom_range(0, 7);
            fill_words();
            run_burst("rand", m, 0, 1'($urandom_range(0, 1)), AW'($urandom), l,
                      $urandom_range(0, 2), $urandom_range(0, 40), 0,
                      ($urandom_range(0, 4) == 0) ? $urandom_range(0, l) : -1, 0, -1);
            req_i = 2'b00;
        end

        repeat (2) @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wbm_burst_arbiter.md
# wbm_burst_arbiter

Shares the single SPI-side Wishbone master port (the `wbm_*` signals) between two requesters, such as a host command path and a register/configuration path. It arbitrates requests round-robin, latches the granted requester's command, and runs one pipelined Wishbone burst. During the burst it counts strobes and acknowledges, paces write data and returns read data. It completes on the final acknowledge, on error, or on a watchdog timeout.

## Interface
Parameters:
- data_width_g, 8, data width
- blen_width_g, 9, burst length width (`wbm_tga_o`)
- addr_width_g, 10, address width
- timeout_g, 255, maximum cycles without an acknowledge before abort (≥1)

Ports:
- clock  in  1  single clock for all logic
- rst  in  1  synchronous reset, active-high
- req_i  in  2  per-requester command request; held until gnt_o
- gnt_o  out  2  one-hot, one-cycle pulse; command fields sampled in this cycle
- req_we_i  in  2  1 = write burst, 0 = read burst
- req_adr_i  in  2×addr_width_g  start address
- req_len_i  in  2×blen_width_g  burst length in words minus 1 (0 = 1 word)
- req_tgc_i, req_tgd_i  in  2 each  forwarded to `wbm_tgc_o` / `wbm_tgd_o`
- wr_dat_i  in  2×data_width_g  current write word of each requester
- wr_ack_o  out  2  pulse: current write word consumed; present the next word on the following cycle
- rd_dat_o  out  data_width_g  read word (shared)
- rd_val_o  out  2  pulse: rd_dat_o valid for that requester
- done_o, err_o  out  2 each  completion pulse; err_o is coincident with done_o on failure
- wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_tga_o, wbm_dat_o, wbm_tgc_o, wbm_tgd_o  out  Wishbone master outputs
- wbm_dat_i, wbm_stall_i, wbm_ack_i, wbm_err_i  in  Wishbone master inputs

## Operation
State machine states: IDLE, ISSUE, DRAIN, FINISH.

- **IDLE**
  - If any req_i bit is set, arbitrate round-robin: the requester not granted last wins a tie; after reset, requester 0 is favoured.
  - Pulse gnt_o.
  - Latch we, adr, len, tgc, tgd and the owner index.
  - Load strobe counter = len+1 and ack counter = len+1.
  - Go to ISSUE.
- **ISSUE**
  - cyc=1, stb=1. A strobe is accepted when stb & !stall.
  - On each accept: decrement the strobe counter, increment wbm_adr_o by 1 (wraps modulo 2^addr_width_g), and on writes pulse wr_ack_o[owner].
  - On the last accept, go to DRAIN with stb=0.
- **DRAIN**
  - cyc=1, stb=0. Wait until the ack counter reaches 0.
- **Acknowledge handling** (ISSUE or DRAIN)
  - Each wbm_ack_i decrements the ack counter.
  - On reads, capture wbm_dat_i into rd_dat_o and pulse rd_val_o[owner] one cycle later.
  - Extra acks once the counter is 0 are ignored.
- **FINISH**
  - Entered when the ack counter hits 0, or on wbm_err_i, or on watchdog expiry.
  - cyc=stb=0 and done_o[owner] pulses, both for one cycle.
  - err_o[owner] also pulses on error or timeout. Go to IDLE.
- **Error**
  - wbm_err_i has priority over a simultaneous ack; that ack is not counted and no read data is delivered for it.
- **Watchdog**
  - Counter reloads to timeout_g on every ack and on entry to ISSUE.
  - It decrements each cycle cyc is high without an ack; on reaching 0, abort.
- **Output hold**
  - wbm_tga_o holds len+1, truncated to blen_width_g, for the whole cycle.
  - wbm_we_o, wbm_tgc_o and wbm_tgd_o hold their latched values.
  - wbm_dat_o = wr_dat_i[owner] while stb=1 and we=1; 0 otherwise.
- **Requests**
  - req_i from the owner, or from the other requester, is ignored until IDLE.

## Timing
- All registered outputs reset to 0: gnt, wr_ack, rd_dat, rd_val, done, err, and all `wbm_*` outputs. The round-robin pointer resets to favour requester 0.
- Reset asserted mid-burst forces IDLE at the next edge. cyc and stb drop at that edge, and no done_o is produced.
- Cycle-level sequence:
  - gnt_o is high in cycle T.
  - cyc and stb first rise in T+1.
  - Minimum 1-word burst with no stall and ack in the same cycle as stb: ack at T+1, done_o at T+2.
  - Back-to-back grants: IDLE lasts at least 1 cycle after FINISH.
- wr_ack_o is combinational on strobe acceptance, in the same cycle as stb & !stall.

## Structure
- Package `wbm_arb_pkg`: state enum (IDLE, ISSUE, DRAIN, FINISH) and the constant num_req_c = 2.
- Sub-module `rr_arbiter2`: 2-input round-robin arbiter with the last-grant pointer register, updated on grant.

## Test plan
- **Single write:** req_i=01, we=1, adr=0x010, len=3, no stall, ack 1 cycle after each stb.
  - 4 strobes at adr 0x010–0x013 with tga=4.
  - 4 wr_ack_o[0] pulses, then done_o[0]; err_o=0.
- **Read with stalls:** req_i=10, we=0, len=1, stall high for 2 cycles on the first strobe, wbm_dat_i=0xA5 then 0x5A.
  - rd_val_o[1] pulses twice with 0xA5 then 0x5A.
  - done_o[1] pulses; cyc is high for 4 cycles.
- **Contention:** req_i=11 held.
  - Grants alternate 0, 1, 0, 1 across 4 bursts; no overlap of cyc.
- **Error:** wbm_err_i on the 2nd ack of a len=3 write, with ack also high in that cycle.
  - Burst aborts: cyc drops next cycle; done_o and err_o pulse.
  - Ack counter does not decrement.
- **Timeout:** timeout_g=8, with no ack after the strobes.
  - Abort after 8 cycles: err_o pulses and cyc drops.
- **Reset mid-burst:** rst asserted during DRAIN.
  - All outputs are 0 next cycle; no done_o.
  - A subsequent request from requester 1 is granted normally.
